add_sequencer: RTL
==================

ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 Parameter BITS, default 8, operand/result width in two's complement; BITS SHALL be 2 or greater.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 in_valid  in  1  in_data holds an operand.
REQ-005 in_ready  out  1  block accepts an operand this cycle.
REQ-006 in_data  in  BITS  signed operand; the first accepted value is A, the second is B.
REQ-007 A, B  out  BITS each  registered operands driven to the downstream adder.
REQ-008 S  in  BITS  signed sum returned by the adder, combinational from A and B.
REQ-009 Z, N, P  in  1 each  adder flags: zero, negative, even.
REQ-010 out_valid  out  1  result registers hold a complete result.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 out_sum  out  BITS  registered S.
REQ-013 out_z, out_n, out_p  out  1 each  registered Z, N, P.
REQ-014 out_ovf  out  1  signed overflow of A+B.
REQ-015 out_count  out  8  completed-transaction counter.

Function
REQ-016 FSM states SHALL be LOAD_A, LOAD_B, EXEC, HOLD.
REQ-017 in_ready SHALL be 1 in LOAD_A and LOAD_B, and 0 in EXEC and HOLD.
REQ-018 Handshake SHALL be in_valid && in_ready; in LOAD_A it captures in_data into A and goes to LOAD_B; in LOAD_B it captures in_data into B and goes to EXEC.
REQ-019 Without a handshake, LOAD_A/LOAD_B SHALL hold state and keep A/B unchanged; in_valid may drop between operands.
REQ-020 EXEC SHALL last exactly one cycle: register S, Z, N, P into out_sum/out_z/out_n/out_p, register out_ovf = (A[BITS-1]==B[BITS-1]) && (S[BITS-1]!=A[BITS-1]), then go to HOLD.
REQ-021 out_valid SHALL be 1 exactly in HOLD.
REQ-022 Latency: out_valid SHALL rise 2 cycles after the B handshake edge (B capture edge, then EXEC capture edge).
REQ-023 In HOLD, out_valid && out_ready SHALL increment out_count modulo 256 (255 wraps to 0) and go to LOAD_A.
REQ-024 While HOLD persists, out_sum, out_z, out_n, out_p and out_ovf SHALL stay stable, and A/B SHALL be held.
REQ-025 in_valid in EXEC or HOLD SHALL be ignored; no operand is consumed.
REQ-026 out_ready outside HOLD SHALL have no effect.
REQ-027 A new A SHALL be accepted no earlier than the cycle after the HOLD handshake; no back-to-back overlap.

Reset
REQ-028 When rst_n=0 at a clock edge, the block SHALL reset: state=LOAD_A; A, B, out_sum = 0; out_z, out_n, out_p, out_ovf = 0; out_count = 0; out_valid = 0.
REQ-029 Reset in any state, including mid-load or HOLD, SHALL discard partial operands and pending results; in_ready=1 the cycle after rst_n returns to 1.
REQ-030 A handshake coincident with active reset SHALL be ignored.

Structure
REQ-031 Shared package add_pkg SHALL hold the BITS default and the state enum type (LOAD_A, LOAD_B, EXEC, HOLD).
REQ-032 The adder SHALL stay external, with no sub-module inside add_sequencer; the bench SHALL instantiate add_sequencer plus the adder (or a model computing S=A+B, Z=(S==0), N=S[BITS-1], P=~S[0]).

Verification (BITS=8)
REQ-033 Basic: in 5 then 3, out_ready=1 -> out_sum=8, out_z=0, out_n=0, out_p=1, out_ovf=0, out_valid 2 cycles after B; out_count=1.
REQ-034 Zero/negative: in -7 then 7 -> out_sum=0, out_z=1, out_p=1; in -7 then 2 -> out_sum=-5 (0xFB), out_n=1, out_p=0.
REQ-035 Overflow: in 100 then 100 -> out_sum=0xC8, out_ovf=1; in -128 then -1 -> out_sum=0x7F, out_ovf=1; in 127 then -1 -> out_ovf=0.
REQ-036 Backpressure: out_ready=0 for 5 cycles in HOLD, with in_valid=1 toggling data -> outputs stable, in_ready=0, no capture; out_ready=1 -> LOAD_A next cycle.
REQ-037 Reset mid-operation: A=9 accepted, rst_n=0 in LOAD_B -> all outputs 0; then in 1 then 2 -> out_sum=3.
REQ-038 Counter wrap: 256 transactions -> out_count goes 255 then 0.

Source files
------------

// File: rtl/add_sequencer_pkg.sv
// add_pkg: shared width default and FSM state type for the add sequencer.
package add_pkg;
    localparam int BITS_DEFAULT = 8;
    typedef enum logic [1:0] {LOAD_A, LOAD_B, EXEC, HOLD} state_e;
endpackage

// File: rtl/add_sequencer_if.sv
// add_sequencer_if: operand input, external adder and result handshake signals.
interface add_sequencer_if #(parameter int BITS = add_pkg::BITS_DEFAULT);
    logic            in_valid, in_ready;
    logic [BITS-1:0] in_data, A, B, S, out_sum;
    logic            Z, N, P;
    logic            out_valid, out_ready, out_z, out_n, out_p, out_ovf;
    logic [7:0]      out_count;
    modport slave (
        input  in_valid, in_data, S, Z, N, P, out_ready,
        output in_ready, A, B, out_valid, out_sum, out_z, out_n, out_p, out_ovf, out_count
    );
    modport master (
        output in_valid, in_data, S, Z, N, P, out_ready,
        input  in_ready, A, B, out_valid, out_sum, out_z, out_n, out_p, out_ovf, out_count
    );
endinterface

// File: rtl/add_sequencer.sv
// add_sequencer: loads two operands, samples an external adder once, holds the result until taken.
module add_sequencer
    import add_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    add_sequencer_if.slave bus
);
    state_e          state_q, state_d;
    logic [BITS-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            z_q, z_d, n_q, n_d, p_q, p_d, ovf_q, ovf_d;
    logic [7:0]      count_q, count_d;
    logic            in_hs;

    assign in_hs = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        z_d     = z_q;
        n_d     = n_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        case (state_q)
            LOAD_A: if (in_hs) begin
                a_d     = bus.in_data;
                state_d = LOAD_B;
            end
            LOAD_B: if (in_hs) begin
                b_d     = bus.in_data;
                state_d = EXEC;
            end
            EXEC: begin
                sum_d   = bus.S;
                z_d     = bus.Z;
                n_d     = bus.N;
                p_d     = bus.P;
                // like-signed operands producing an opposite-signed sum
                ovf_d   = (a_q[BITS-1] == b_q[BITS-1]) && (bus.S[BITS-1] != a_q[BITS-1]);
                state_d = HOLD;
            end
            HOLD: if (bus.out_ready) begin
                count_d = count_q + 8'd1;
                state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            p_q     <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            z_q     <= z_d;
            n_q     <= n_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign bus.out_valid = state_q == HOLD;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_z     = z_q;
    assign bus.out_n     = n_q;
    assign bus.out_p     = p_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_count = count_q;
endmodule
